multicycle_control: RTL
=======================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled only on the rising edge of clk.
REQ-003 SHALL have port Op, input, 6 bits: instruction opcode field [31:26] taken from the instruction register.
REQ-004 SHALL have port Funct, input, 6 bits: R-type function field [5:0].
REQ-005 SHALL have port Zero, input, 1 bit: ALU zero flag.
REQ-006 SHALL have outputs IorD, IRWrite, MemWrite, RegWrite, RegDst, MemtoReg and ALUSrcA, each 1 bit.
REQ-007 SHALL have outputs ALUSrcB and PCSrc, each 2 bits.
REQ-008 SHALL have output ALUControl, 3 bits, encoded AND=000, OR=001, ADD=010, SUB=100, MUL=101, SLT=110.
REQ-009 SHALL have output PCEn, 1 bit: PC load enable, equal to PCWrite | (Branch & Zero).
REQ-010 SHALL have output State, 4 bits: current state code for debug.

Function
REQ-011 SHALL implement a Moore FSM with these state codes:
- FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5
- EXECUTE 6, ALUWB 7, BRANCH 8, ADDIEX 9, ADDIWB 10, JUMP 11
REQ-012 SHALL make the FETCH to DECODE transition unconditionally.
REQ-013 SHALL, from DECODE, select the next state by Op:
- 100011 (lw) and 101011 (sw): MEMADR
- 000000: EXECUTE
- 000100: BRANCH
- 001000: ADDIEX
- 000010: JUMP
- any other opcode: FETCH, with no write enable asserted.
REQ-014 SHALL, from MEMADR, go to MEMRD for lw and MEMWR for sw.
REQ-015 SHALL make these transitions: MEMRD to MEMWB, EXECUTE to ALUWB, ADDIEX to ADDIWB.
REQ-016 SHALL return to FETCH from MEMWB, MEMWR, ALUWB, ADDIWB, BRANCH and JUMP.
REQ-017 SHALL give these total cycle counts including FETCH: lw 5; sw, R-type and addi 4; beq and j 3; illegal opcode 2.
REQ-018 SHALL drive these outputs in FETCH: IorD=0, ALUSrcA=0, ALUSrcB=01, ALUControl=ADD, PCSrc=00, IRWrite=1, PCWrite=1.
REQ-019 SHALL drive ALUSrcA=0, ALUSrcB=11 and ALUControl=ADD in DECODE (branch target).
REQ-020 SHALL drive ALUSrcA=1, ALUSrcB=10 and ALUControl=ADD in MEMADR and ADDIEX.
REQ-021 SHALL drive IorD=1 in MEMRD, and IorD=1 with MemWrite=1 in MEMWR.
REQ-022 SHALL drive RegWrite=1, RegDst=0 and MemtoReg=1 in MEMWB.
REQ-023 SHALL drive RegWrite=1, RegDst=0 and MemtoReg=0 in ADDIWB.
REQ-024 SHALL drive ALUSrcA=1, ALUSrcB=00 and ALUControl from Funct in EXECUTE:
- 100000: ADD; 100010: SUB; 100100: AND; 100101: OR; 101010: SLT; 011000: MUL
- any other Funct: 010 (ADD).
REQ-025 SHALL drive RegWrite=1, RegDst=1 and MemtoReg=0 in ALUWB.
REQ-026 SHALL drive ALUSrcA=1, ALUSrcB=00, ALUControl=SUB, PCSrc=01 and Branch=1 in BRANCH.
REQ-027 SHALL drive PCSrc=10 and PCWrite=1 in JUMP.
REQ-028 SHALL drive every output not listed for a state to 0; ALUControl SHALL default to ADD in every state.
REQ-029 SHALL evaluate PCEn combinationally in BRANCH, so the PC loads in that same cycle only when Zero=1.
REQ-030 SHALL sample Op only in DECODE and MEMADR, and Funct only in EXECUTE; input changes in any other state SHALL NOT affect behaviour.

Reset
REQ-031 SHALL load State=FETCH on any rising edge of clk with reset=1, whatever the current state, including mid-instruction.
REQ-032 SHALL force IRWrite, MemWrite, RegWrite, PCWrite, Branch and PCEn to 0 while reset=1; all other outputs SHALL take their FETCH values.
REQ-033 SHALL resume the normal FETCH behaviour of REQ-018 on the first cycle with reset=0.

Verification
REQ-034 Reset held for 2 cycles, then released: State=0 and PCEn=0 while reset=1; the first cycle after release shows IRWrite=1, PCEn=1 and ALUControl=010.
REQ-035 Op=100011 (lw): State sequence 0,1,2,3,4,0; exactly one MemWB cycle with RegWrite=1 and MemtoReg=1; MemWrite=0 throughout.
REQ-036 Op=000000 with Funct=100010, then Funct=011000: EXECUTE shows ALUControl=100, then 101; ALUWB shows RegWrite=1 and RegDst=1.
REQ-037 Op=000100 (beq) with Zero=1, then with Zero=0: the BRANCH cycle shows PCEn=1, then PCEn=0; ALUControl=100 in both; back to FETCH after 3 cycles.
REQ-038 Op=111111 (illegal): State sequence 0,1,0; no RegWrite, MemWrite or PCEn in DECODE.
REQ-039 Reset asserted in MEMRD: next State=0 and no RegWrite pulse occurs; Op=101011 (sw) afterwards gives State sequence 0,1,2,5,0 with MemWrite=1 only in state 5.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Brief    : Moore-style main controller for a multicycle MIPS-like datapath.
//            Sequences FETCH/DECODE/execute/writeback steps per opcode and
//            decodes the R-type function field into the ALU operation.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic       IorD,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       PCEn,
    output logic [3:0] State
);

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] C_OP_LW   = 6'b100011;
    localparam logic [5:0] C_OP_SW   = 6'b101011;
    localparam logic [5:0] C_OP_RT   = 6'b000000;
    localparam logic [5:0] C_OP_BEQ  = 6'b000100;
    localparam logic [5:0] C_OP_ADDI = 6'b001000;
    localparam logic [5:0] C_OP_J    = 6'b000010;

    localparam logic [2:0] C_ALU_AND = 3'b000;
    localparam logic [2:0] C_ALU_OR  = 3'b001;
    localparam logic [2:0] C_ALU_ADD = 3'b010;
    localparam logic [2:0] C_ALU_SUB = 3'b100;
    localparam logic [2:0] C_ALU_MUL = 3'b101;
    localparam logic [2:0] C_ALU_SLT = 3'b110;

    state_t state_q;
    state_t state_d;
    // While reset is held the outputs look like FETCH (writes suppressed below)
    state_t out_state;
    logic   pc_write;
    logic   branch;
    logic [2:0] funct_alu;

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection; Op only matters in DECODE and MEMADR
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:   state_d = S_DECODE;
            S_DECODE: begin
                case (Op)
                    C_OP_LW,
                    C_OP_SW:   state_d = S_MEMADR;
                    C_OP_RT:   state_d = S_EXECUTE;
                    C_OP_BEQ:  state_d = S_BRANCH;
                    C_OP_ADDI: state_d = S_ADDIEX;
                    C_OP_J:    state_d = S_JUMP;
                    default:   state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                if (Op == C_OP_LW) begin
                    state_d = S_MEMRD;
                end else if (Op == C_OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD:   state_d = S_MEMWB;
            S_EXECUTE: state_d = S_ALUWB;
            S_ADDIEX:  state_d = S_ADDIWB;
            default:   state_d = S_FETCH;
        endcase
    end

    // R-type function field to ALU operation; unknown codes fall back to ADD
    always_comb begin
        funct_alu = C_ALU_ADD;
        case (Funct)
            6'b100000: funct_alu = C_ALU_ADD;
            6'b100010: funct_alu = C_ALU_SUB;
            6'b100100: funct_alu = C_ALU_AND;
            6'b100101: funct_alu = C_ALU_OR;
            6'b101010: funct_alu = C_ALU_SLT;
            6'b011000: funct_alu = C_ALU_MUL;
            default:   funct_alu = C_ALU_ADD;
        endcase
    end

    // Moore output decode; every output defaults to 0 and ALUControl to ADD
    always_comb begin
        out_state  = reset ? S_FETCH : state_q;
        IorD       = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        PCSrc      = 2'b00;
        ALUControl = C_ALU_ADD;
        pc_write   = 1'b0;
        branch     = 1'b0;
        case (out_state)
            S_FETCH: begin
                ALUSrcB  = 2'b01;
                IRWrite  = 1'b1;
                pc_write = 1'b1;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
            end
            S_MEMADR,
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MEMRD: begin
                IorD = 1'b1;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            S_EXECUTE: begin
                ALUSrcA    = 1'b1;
                ALUControl = funct_alu;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUControl = C_ALU_SUB;
                PCSrc      = 2'b01;
                branch     = 1'b1;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
            end
            S_JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: begin
                ALUControl = C_ALU_ADD;
            end
        endcase
        if (reset) begin
            IRWrite  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            pc_write = 1'b0;
            branch   = 1'b0;
        end
    end

    // Branch resolves in its own cycle from the live Zero flag
    assign PCEn  = pc_write | (branch & Zero);
    assign State = out_state;

endmodule
`default_nettype wire
